// File: rtl/median_pkg.sv
// Shared constants, pixel type and sizing helpers for the KxK median filter.
package median_pkg;

   localparam int COORD_W = 12;
   localparam int DEF_CH  = 3;
   localparam int DEF_DW  = 8;

   typedef logic [DEF_CH*DEF_DW-1:0] pixel_t;

   function automatic int med_n(input int k);
      return k * k;
   endfunction

   function automatic int med_centre(input int k);
      return (k * k) / 2;
   endfunction

   // Line-buffer rows above the centre, centre column offset, window register, sort stages.
   function automatic int med_latency(input int k, input int h_size);
      return (k / 2) * h_size + k / 2 + 1 + k * k;
   endfunction

endpackage

// File: rtl/median_sort_net.sv
// Pipelined odd-even transposition sort of one channel's KxK window; outputs the median.
module median_sort_net
   import median_pkg::*;
#(
   parameter int K  = 5,
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [K*K*DW-1:0] window,
   output logic [DW-1:0]     median
);

   localparam int N = med_n(K);

   for (genvar s = 0; s < N; s++) begin : g_stage
      logic [N-1:0][DW-1:0] d;
      logic [N-1:0][DW-1:0] nxt;
      logic [N-1:0][DW-1:0] q;

      if (s == 0) begin : g_in
         assign d = window;
      end else begin : g_link
         assign d = g_stage[s-1].q;
      end

      // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...; equal values stay put.
      always_comb begin
         nxt = d;
         for (int i = s % 2; i + 1 < N; i += 2) begin
            if (d[i] > d[i+1]) begin
               nxt[i]   = d[i+1];
               nxt[i+1] = d[i];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else begin
            q <= nxt;
         end
      end
   end

   assign median = g_stage[N-1].q[med_centre(K)];

endmodule

// File: rtl/median_filter_kxk.sv
// KxK per-channel median filter for the pixel path with frame-synchronous bypass.
// Define MEDIAN_BORDER_PASS_EN to output the unfiltered centre pixel within K/2 of an active edge.
module median_filter_kxk
   import median_pkg::*;
#(
   parameter int K      = 5,
   parameter int CH     = 3,
   parameter int DW     = 8,
   parameter int H_SIZE = 83,
   parameter int ACT_W  = 64,
   parameter int ACT_H  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bypass,
   input  logic             de,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [CH*DW-1:0] pixel_in,
   output logic             de_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [CH*DW-1:0] pixel_out
);

   localparam int PW    = CH * DW;
   localparam int N     = med_n(K);
   localparam int R     = K / 2;
   localparam int L     = med_latency(K, H_SIZE);
   localparam int DC    = L - N;
   localparam int PTR_W = $clog2(H_SIZE);

   if (!(K == 3 || K == 5) || ACT_W <= 2 * R || ACT_H <= 2 * R) begin : g_bad_config
      $error("median_filter_kxk: unsupported window size or active geometry");
   end

   logic [PTR_W-1:0]          wr_ptr;
   logic [PW-1:0]             line_mem [K-1][H_SIZE];
   logic [K-1:0][PW-1:0]      tap;
   logic [K-1:0][K-1:0][PW-1:0] win;
   logic [CH-1:0][N*DW-1:0]   sort_in;
   logic [CH-1:0][DW-1:0]     med;
   logic [PW-1:0]             med_pix;
   logic [L-1:0][2:0]         sync_dly;
   logic                      vs_rise_in;
   logic                      bypass_lat;
   logic                      de_c;
   logic                      vs_c;
   logic                      vs_c_prev;
   logic                      vs_rise_c;
   logic                      bypass_frame;
   logic                      sel_c;
   logic [N-1:0][PW-1:0]      ctr_dly;
   logic [N-1:0]              sel_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (wr_ptr == PTR_W'(H_SIZE - 1)) begin
         wr_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Buffers are cascaded: tap r is the input delayed by exactly r lines of H_SIZE clocks.
   always_comb begin
      tap[0] = pixel_in;
      for (int r = 1; r < K; r++) begin
         tap[r] = line_mem[r-1][wr_ptr];
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < K - 1; r++) begin
         line_mem[r][wr_ptr] <= tap[r];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
      end else begin
         for (int r = 0; r < K; r++) begin
            win[r][0] <= tap[r];
            for (int c = 1; c < K; c++) begin
               win[r][c] <= win[r][c-1];
            end
         end
      end
   end

   always_comb begin
      sort_in = '0;
      for (int ch = 0; ch < CH; ch++) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               sort_in[ch][(r*K+c)*DW +: DW] = win[r][c][ch*DW +: DW];
            end
         end
      end
   end

   for (genvar ch = 0; ch < CH; ch++) begin : g_chan
      median_sort_net #(
         .K  (K),
         .DW (DW)
      ) u_sort (
         .clk    (clk),
         .rst_n  (rst_n),
         .window (sort_in[ch]),
         .median (med[ch])
      );
   end

   assign med_pix = med;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_dly <= '0;
      end else begin
         sync_dly <= {sync_dly[L-2:0], de, hsync, vsync};
      end
   end

   assign {de_out, hsync_out, vsync_out} = sync_dly[L-1];

   // Tap DC-1 lines up with the window centre, so frame/position state follows the centre pixel.
   assign vs_rise_in = vsync & ~sync_dly[0][0];
   assign de_c       = sync_dly[DC-1][2];
   assign vs_c       = sync_dly[DC-1][0];
   assign vs_c_prev  = sync_dly[DC][0];
   assign vs_rise_c  = vs_c & ~vs_c_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bypass_lat   <= 1'b0;
         bypass_frame <= 1'b0;
      end else begin
         if (vs_rise_in) begin
            bypass_lat <= bypass;
         end
         if (vs_rise_c) begin
            bypass_frame <= bypass_lat;
         end
      end
   end

`ifdef MEDIAN_BORDER_PASS_EN
   logic               de_c_prev;
   logic [COORD_W-1:0] x_cnt;
   logic [COORD_W-1:0] y_cnt;
   logic               border_c;

   assign de_c_prev = sync_dly[DC][2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (!de_c) begin
            x_cnt <= '0;
         end else if (x_cnt != '1) begin
            x_cnt <= x_cnt + 1'b1;
         end
         if (vs_rise_c) begin
            y_cnt <= '0;
         end else if (!de_c && de_c_prev && y_cnt != '1) begin
            y_cnt <= y_cnt + 1'b1;
         end
      end
   end

   assign border_c = (x_cnt < COORD_W'(R)) || (x_cnt >= COORD_W'(ACT_W - R)) ||
                     (y_cnt < COORD_W'(R)) || (y_cnt >= COORD_W'(ACT_H - R));
   assign sel_c    = bypass_frame | border_c;
`else
   assign sel_c    = bypass_frame;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr_dly <= '0;
         sel_dly <= '0;
      end else begin
         ctr_dly <= {ctr_dly[N-2:0], win[R][R]};
         sel_dly <= {sel_dly[N-2:0], sel_c};
      end
   end

   assign pixel_out = sel_dly[N-1] ? ctr_dly[N-1] : med_pix;

endmodule

// File: tb/tb_median_filter_kxk.sv
// Scoreboard bench for median_filter_kxk (K=3, 64x64 active, H_SIZE=83).
`timescale 1ns/1ps
module tb_median_filter_kxk;
   import median_pkg::*;

   localparam int K       = 3;
   localparam int CH      = 3;
   localparam int DW      = 8;
   localparam int H_SIZE  = 83;
   localparam int ACT_W   = 64;
   localparam int ACT_H   = 64;
   localparam int L_EXP   = 94;
   localparam int V_TOTAL = 70;
   localparam int V_ACT0  = 3;

   typedef enum logic [1:0] {FLAT, IMPULSE, BLOCK, RAMP} frame_kind_t;

   typedef struct {
      logic   care;
      pixel_t val;
      int     x;
      int     y;
   } exp_t;

   exp_t   exp_q[$];
   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   bypass = 1'b0;
   logic   de = 1'b0;
   logic   hsync = 1'b0;
   logic   vsync = 1'b0;
   pixel_t pixel_in = '0;
   logic   de_out;
   logic   hsync_out;
   logic   vsync_out;
   pixel_t pixel_out;

   int     checks = 0;
   int     failures = 0;
   logic [2:0] hist [L_EXP];
   int     hp = 0;
   int     neg_idx = 0;
   logic   de_in_prev = 1'b0;
   logic   de_out_prev = 1'b0;
   logic   de_rise_seen = 1'b0;
   logic   de_out_rise_seen = 1'b0;
   int     de_rise_idx = 0;
   int     de_out_rise_idx = 0;

   always #5 clk = ~clk;

   median_filter_kxk #(
      .K      (K),
      .CH     (CH),
      .DW     (DW),
      .H_SIZE (H_SIZE),
      .ACT_W  (ACT_W),
      .ACT_H  (ACT_H)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bypass    (bypass),
      .de        (de),
      .hsync     (hsync),
      .vsync     (vsync),
      .pixel_in  (pixel_in),
      .de_out    (de_out),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .pixel_out (pixel_out)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic pixel_t in_pixel(frame_kind_t k, int x, int y);
      case (k)
         FLAT:    return 24'h404040;
         IMPULSE: return (x == 10 && y == 10) ? 24'hFFFFFF : 24'h000000;
         BLOCK:   return (x >= 20 && x <= 22 && y >= 20 && y <= 22) ? 24'hFF0000 : 24'h000000;
         default: return {3{8'(x)}};
      endcase
   endfunction

   function automatic pixel_t bg_pixel(frame_kind_t k);
      return (k == FLAT) ? 24'h404040 : 24'h000000;
   endfunction

   // Hand-derived expectations: an isolated pixel vanishes, the 3x3 block survives as a plus.
   function automatic pixel_t exp_pixel(frame_kind_t k, logic bp, int x, int y);
      if (bp) return in_pixel(k, x, y);
      case (k)
         FLAT:    return 24'h404040;
         IMPULSE: return 24'h000000;
         BLOCK:   return ((x == 21 && y >= 20 && y <= 22) || (y == 21 && x >= 20 && x <= 22)) ?
                         24'hFF0000 : 24'h000000;
         default: return in_pixel(k, x, y);
      endcase
   endfunction

   function automatic logic exp_care(frame_kind_t k, int x, int y);
`ifdef MEDIAN_BORDER_PASS_EN
      return 1'b1;
`else
      if (k == RAMP) return (x >= 1 && x <= ACT_W - 2 && y >= 1 && y <= ACT_H - 2);
      return 1'b1;
`endif
   endfunction

   task automatic applyStimulus(input frame_kind_t kind, input int chg_line, input logic chg_val,
                                input int rst_line);
      logic frame_bp;
      logic care_on;
      logic active;
      exp_t e;
      frame_bp = bypass;
      care_on  = 1'b1;
      for (int ln = 0; ln < V_TOTAL; ln++) begin
         for (int h = 0; h < H_SIZE; h++) begin
            @(posedge clk);
            #1;
            if (ln == chg_line && h == 0) bypass = chg_val;
            if (ln == rst_line && h == 30) begin
               rst_n = 1'b0;
               exp_q.delete();
               care_on = 1'b0;
               #1;
               checkOutput("rst_de_out", 32'(de_out), 32'h0);
               checkOutput("rst_hsync_out", 32'(hsync_out), 32'h0);
               checkOutput("rst_vsync_out", 32'(vsync_out), 32'h0);
               checkOutput("rst_pixel_out", 32'(pixel_out), 32'h0);
            end
            if (ln == rst_line && h == 33) rst_n = 1'b1;
            active = (ln >= V_ACT0) && (ln < V_ACT0 + ACT_H) && (h < ACT_W);
            de     = active;
            hsync  = (h >= 70) && (h < 76);
            vsync  = (ln < 2);
            if (active) begin
               pixel_in = in_pixel(kind, h, ln - V_ACT0);
               if (rst_n) begin
                  e.care = care_on && exp_care(kind, h, ln - V_ACT0);
                  e.val  = exp_pixel(kind, frame_bp, h, ln - V_ACT0);
                  e.x    = h;
                  e.y    = ln - V_ACT0;
                  exp_q.push_back(e);
               end
            end else begin
               pixel_in = bg_pixel(kind);
            end
         end
      end
   endtask

   // Monitor: sync outputs against a delayed copy of the inputs, pixels against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      neg_idx++;
      if (!rst_n) begin
         for (int i = 0; i < L_EXP; i++) hist[i] = 3'b000;
         checkOutput("sync_in_reset", {29'h0, de_out, hsync_out, vsync_out}, 32'h0);
      end else begin
         checkOutput($sformatf("sync_delay@%0d", neg_idx), {29'h0, de_out, hsync_out, vsync_out},
                     {29'h0, hist[hp]});
         hist[hp] = {de, hsync, vsync};
         hp = (hp + 1) % L_EXP;
         if (de_out) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL pixel_unexpected: got %h, expected no output", pixel_out);
            end else begin
               e = exp_q.pop_front();
               if (e.care) checkOutput($sformatf("pixel(%0d,%0d)", e.x, e.y), 32'(pixel_out), 32'(e.val));
            end
         end
      end
      if (!de_rise_seen && de && !de_in_prev) begin
         de_rise_seen = 1'b1;
         de_rise_idx  = neg_idx;
      end
      if (de_rise_seen && !de_out_rise_seen && de_out && !de_out_prev) begin
         de_out_rise_seen = 1'b1;
         de_out_rise_idx  = neg_idx;
      end
      de_in_prev  = de;
      de_out_prev = de_out;
   end

   initial begin
      for (int i = 0; i < L_EXP; i++) hist[i] = 3'b000;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(FLAT,    -1, 1'b0, -1);
      applyStimulus(IMPULSE, 30, 1'b1, -1);
      applyStimulus(IMPULSE, -1, 1'b0, -1);
      applyStimulus(BLOCK,   30, 1'b1, -1);
      applyStimulus(BLOCK,   30, 1'b0, -1);
      applyStimulus(RAMP,    -1, 1'b0, -1);
      applyStimulus(FLAT,    -1, 1'b0, 40);
      applyStimulus(FLAT,    -1, 1'b0, -1);
      for (int i = 0; i < L_EXP + 20; i++) begin
         @(posedge clk);
         #1;
         de       = 1'b0;
         hsync    = 1'b0;
         vsync    = 1'b0;
         pixel_in = '0;
      end
      @(negedge clk);
      #1;
      if (de_rise_seen && de_out_rise_seen) begin
         checkOutput("de_latency", 32'(de_out_rise_idx - de_rise_idx), 32'(L_EXP));
      end else begin
         checks++;
         failures++;
         $display("[TB] FAIL de_latency: got no de_out rise, expected %0d", L_EXP);
      end
      checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/median_filter_kxk.md
# median_filter_kxk

Parametrised median filter for the HDMI video path. Successor to the fixed 5x5 median stage, with selectable window size K (3 or 5), channel count and per-channel width. Sits between the HDMI input decoder and HDMI output encoder on the pixel clock. Processes each channel independently and supports a frame-synchronous bypass mode.

## Interface
Parameters:
- K, 5, window size; legal values 3 or 5
- CH, 3, number of colour channels packed in a pixel
- DW, 8, bits per channel
- H_SIZE, 83, total line length in clocks including blanking (83 for the 64x64 simulation timing)
- ACT_W, 64, active pixels per line
- ACT_H, 64, active lines per frame

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- bypass  in  1  1 = pass centre pixel, 0 = median; sampled at frame start
- de  in  1  data enable
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- pixel_in  in  CH*DW  pixel; channel 0 in the MSBs
- de_out  out  1  de delayed by L
- hsync_out  out  1  hsync delayed by L
- vsync_out  out  1  vsync delayed by L
- pixel_out  out  CH*DW  filtered pixel, aligned with de_out

## Operation
- Line buffers:
  - K-1 circular buffers, H_SIZE deep, CH*DW wide.
  - One shared write pointer, incremented every clock; it wraps from H_SIZE-1 to 0.
  - Buffer contents are not reset.
- Window: KxK register array, shifted every clock. Column 0 is fed from pixel_in and the buffer outputs.
- Sort: per channel, an odd-even transposition network on N = K*K values.
  - N registered stages; stage s compares even pairs if s is even, odd pairs if s is odd.
  - The median is element N/2 of the sorted output.
  - Comparisons are unsigned DW-bit; ties keep order.
- Position tracking:
  - x counts de-high clocks and clears when de falls.
  - y increments on each de falling edge and clears on the vsync rising edge.
  - Both saturate; neither wraps inside a frame.
  - The centre coordinate (x-K/2, y-K/2) is carried down the pipeline together with the centre pixel.
- Bypass: bypass is latched on the vsync rising edge. The latched value applies to the whole following frame, so changing bypass mid-frame has no effect until the next vsync.
- Output select (latched bypass, or border flag with the macro) chooses the delayed centre pixel instead of the median.

## Timing
- Latency L = (K/2)*H_SIZE + K/2 + 1 + K*K clocks. K=3 gives 94; K=5 gives 194.
- de_out, hsync_out and vsync_out are bit-exact copies of their inputs delayed by L.
- Throughput is one pixel per clock with no stalls. Input may be arbitrary during blanking.
- Reset (asynchronous, any time, including mid-frame):
  - All outputs go to 0.
  - Delay lines, pipeline, counters, write pointer and latched bypass go to 0.
  - The first complete frame after reset release (starting at a vsync rising edge) is filtered correctly.
  - Output for the partial frame that was cut by reset is undefined in pixel value, but the sync outputs stay delayed copies of the inputs.

## Configuration
- MEDIAN_BORDER_PASS_EN defined:
  - A centre pixel within K/2 of any active edge (x<K/2, x>=ACT_W-K/2, y<K/2, y>=ACT_H-K/2) outputs the unfiltered centre pixel.
  - ACT_W and ACT_H are used only for this check.
- Undefined:
  - The raw window median is output everywhere, including windows that reach into blanking or the previous line.
  - No border comparators are built.

## Structure
- Package median_pkg holds:
  - localparam function med_latency(K, H_SIZE)
  - N = K*K and the centre index
  - the coordinate width constant
  - the typedef for a CH*DW pixel word
- Sub-module median_sort_net(K, DW): the pipelined single-channel sort network, instantiated CH times.

## Test plan
All tests use 64x64 frames, H_SIZE=83, K=3, CH=3, DW=8 unless stated.
- Flat frame of 0x404040 → every active pixel_out = 0x404040; de_out rises exactly 94 clocks after de (194 for K=5).
- Single 0xFFFFFF impulse at (10,10) in a black frame:
  - median mode → all active outputs 0x000000.
  - bypass mode → 0xFFFFFF at (10,10) only.
- 3x3 block of 0xFF0000 at x,y=20..22 in black → pixel_out 0xFF0000 at (21,21), (20,21), (22,21), (21,20), (21,22); 0x000000 elsewhere; green and blue always 0.
- bypass toggled at line 30 of frame 1 → frame 1 is fully median-filtered; frame 2 is fully bypassed.
- MEDIAN_BORDER_PASS_EN with a horizontal ramp (pixel = x replicated) → row 0, row 63, column 0 and column 63 outputs equal the input; interior equals the input (the ramp median is unchanged).
- rst_n pulsed low at line 40 → all outputs read 0 within the same clock; the next frame after release matches the flat-frame results.
